dense_layer_tm: RTL and testbench

Time-multiplexed, parametrised successor to the fully parallel dense layer. LANES neurons are computed at once, one input element per cycle. Inputs, weights and biases come from external synchronous-read memories through address ports, not wide parallel buses. Results leave per neuron group on a valid/ready stream, with optional ReLU and arithmetic requantisation shift. The block sits between the flattened conv/pool feature buffer and the next dense layer or the argmax stage.

---
 rtl/dense_pkg.sv | 25 ++
 rtl/dense_layer_tm_if.sv | 36 +++
 rtl/mac_lane.sv | 49 ++++
 rtl/dense_layer_tm.sv | 127 ++++++++++++
 tb/tb_dense_layer_tm.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dense_pkg.sv
// rtl/dense_pkg.sv - shared types and width helpers for the time-multiplexed dense layer
package dense_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC,
        ST_BIAS,
        ST_OUT,
        ST_DONE
    } state_t;

    // Operand widths as multiples of WIDTH: inputs, full products, accumulators
    localparam int IN_MULT   = 2;
    localparam int PROD_MULT = 3;
    localparam int ACC_MULT  = 4;

    function automatic int acc_w(input int width);
        return ACC_MULT * width;
    endfunction

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dense_layer_tm_if.sv
// rtl/dense_layer_tm_if.sv - memory read ports and result stream of the dense layer
interface dense_layer_tm_if
    import dense_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LANES   = 4,
    parameter int IN_SIZE = 196,
    parameter int GROUPS  = 8
) ();

    localparam int IAW = addr_w(IN_SIZE);
    localparam int WAW = addr_w(GROUPS * IN_SIZE);
    localparam int GAW = addr_w(GROUPS);

    logic        [IAW-1:0]             in_addr;
    logic signed [IN_MULT*WIDTH-1:0]   in_data;
    logic        [WAW-1:0]             w_addr;
    logic        [LANES*WIDTH-1:0]     w_data;
    logic        [GAW-1:0]             b_addr;
    logic        [LANES*WIDTH-1:0]     b_data;
    logic                              out_valid;
    logic                              out_ready;
    logic        [GAW-1:0]             out_group;
    logic        [LANES*ACC_MULT*WIDTH-1:0] out_data;

    modport master (
        output in_addr, w_addr, b_addr, out_valid, out_group, out_data,
        input  in_data, w_data, b_data, out_ready
    );

    modport slave (
        input  in_addr, w_addr, b_addr, out_valid, out_group, out_data,
        output in_data, w_data, b_data, out_ready
    );

endinterface

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one signed multiply-accumulate neuron lane with bias, ReLU and shift
module mac_lane
    import dense_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RELU  = 1,
    parameter int SHIFT = 0
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              clr,
    input  logic                              en,
    input  logic                              ld,
    input  logic signed [IN_MULT*WIDTH-1:0]   x,
    input  logic signed [WIDTH-1:0]           w,
    input  logic signed [WIDTH-1:0]           b,
    output logic signed [ACC_MULT*WIDTH-1:0]  y
);

    localparam int AW = acc_w(WIDTH);
    localparam int PW = PROD_MULT * WIDTH;

    logic signed [AW-1:0] acc;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] biased;
    logic signed [AW-1:0] rect;

    // Operands are widened before the multiply so the full product survives
    assign prod   = PW'(x) * PW'(w);
    assign biased = acc + AW'(b);
    assign rect   = ((RELU != 0) && (biased < 0)) ? '0 : biased;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            y   <= '0;
        end else begin
            if (clr) begin
                acc <= '0;
            end else if (en) begin
                acc <= acc + AW'(prod);
            end
            if (ld) begin
                y <= rect >>> SHIFT;
            end
        end
    end

endmodule

// File: rtl/dense_layer_tm.sv
// rtl/dense_layer_tm.sv - time-multiplexed dense layer, LANES neurons per pass over the input
module dense_layer_tm
    import dense_pkg::*;
#(
    parameter int NEURON_NB = 32,
    parameter int IN_SIZE   = 196,
    parameter int WIDTH     = 8,
    parameter int LANES     = 4,
    parameter int RELU      = 1,
    parameter int SHIFT     = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              layer_done,
    dense_layer_tm_if.master  bus
);

    localparam int GROUPS = NEURON_NB / LANES;
    localparam int AW     = acc_w(WIDTH);
    localparam int WAW    = addr_w(GROUPS * IN_SIZE);
    localparam int GAW    = addr_w(GROUPS);
    localparam int JW     = addr_w(IN_SIZE + 1);

    state_t                 state;
    logic [JW-1:0]          j;
    logic [GAW-1:0]         g;
    logic                   lane_clr;
    logic                   lane_en;
    logic                   lane_ld;
    logic [LANES*AW-1:0]    lane_y;

    // Cycle 0 of MAC only issues the first read, so it doubles as the clear slot
    assign lane_clr = (state == ST_MAC) && (j == '0);
    assign lane_en  = (state == ST_MAC) && (j != '0);
    assign lane_ld  = (state == ST_BIAS);
    assign bus.out_data = lane_y;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            j             <= '0;
            g             <= '0;
            busy          <= 1'b0;
            layer_done    <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_group <= '0;
            bus.in_addr   <= '0;
            bus.w_addr    <= '0;
            bus.b_addr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_MAC;
                        busy        <= 1'b1;
                        layer_done  <= 1'b0;
                        j           <= '0;
                        g           <= '0;
                        bus.in_addr <= '0;
                        bus.w_addr  <= '0;
                        bus.b_addr  <= '0;
                    end
                end
                ST_MAC: begin
                    if (j < JW'(IN_SIZE - 1)) begin
                        bus.in_addr <= bus.in_addr + 1'b1;
                        bus.w_addr  <= bus.w_addr + WAW'(1);
                    end
                    if (j == JW'(IN_SIZE)) begin
                        state <= ST_BIAS;
                        j     <= '0;
                    end else begin
                        j <= j + JW'(1);
                    end
                end
                ST_BIAS: begin
                    state         <= ST_OUT;
                    bus.out_valid <= 1'b1;
                    bus.out_group <= g;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (g == GAW'(GROUPS - 1)) begin
                            state <= ST_DONE;
                        end else begin
                            // Weight address simply continues: g*IN_SIZE+IN_SIZE-1 -> (g+1)*IN_SIZE
                            state       <= ST_MAC;
                            g           <= g + GAW'(1);
                            bus.b_addr  <= g + GAW'(1);
                            bus.in_addr <= '0;
                            bus.w_addr  <= bus.w_addr + WAW'(1);
                            j           <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    layer_done <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mac_lane #(
            .WIDTH (WIDTH),
            .RELU  (RELU),
            .SHIFT (SHIFT)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (lane_clr),
            .en      (lane_en),
            .ld      (lane_ld),
            .x       (bus.in_data),
            .w       (bus.w_data[k*WIDTH +: WIDTH]),
            .b       (bus.b_data[k*WIDTH +: WIDTH]),
            .y       (lane_y[k*AW +: AW])
        );
    end

endmodule

// File: tb/tb_dense_layer_tm.sv
// tb/tb_dense_layer_tm.sv - bench for dense_layer_tm in three RELU/SHIFT configurations
module tb_dense_layer_tm;

    localparam int WIDTH     = 8;
    localparam int LANES     = 2;
    localparam int IN_SIZE   = 4;
    localparam int NEURON_NB = 4;
    localparam int GROUPS    = 2;
    localparam int NDUT      = 3;

    typedef struct packed {
        logic [3:0][15:0] x;
        logic [7:0]       w;
        logic [7:0]       b;
        logic [2:0][31:0] e;
    } vec_t;

    typedef struct packed {
        logic [31:0]      grp;
        logic [2:0][63:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic ready = 1'b1;

    always #5 clk = ~clk;

    logic [15:0] in_mem [IN_SIZE];
    logic [15:0] w_mem  [GROUPS*IN_SIZE];
    logic [15:0] b_mem  [GROUPS];

    logic        busy      [NDUT];
    logic        ld        [NDUT];
    logic        o_valid   [NDUT];
    logic [63:0] o_data    [NDUT];
    logic [0:0]  o_group   [NDUT];
    logic [1:0]  o_in_addr [NDUT];
    logic [2:0]  o_w_addr  [NDUT];
    logic [0:0]  o_b_addr  [NDUT];

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    vec_t vecs[5];

    // DUT 0: RELU=1 SHIFT=0, DUT 1: RELU=0 SHIFT=0, DUT 2: RELU=0 SHIFT=2
    for (genvar i = 0; i < NDUT; i++) begin : g_dut
        dense_layer_tm_if #(
            .WIDTH(WIDTH), .LANES(LANES), .IN_SIZE(IN_SIZE), .GROUPS(GROUPS)
        ) bus ();

        always @(posedge clk) begin
            bus.in_data <= in_mem[bus.in_addr];
            bus.w_data  <= w_mem[bus.w_addr];
            bus.b_data  <= b_mem[bus.b_addr];
        end

        assign bus.out_ready = ready;
        assign o_valid[i]    = bus.out_valid;
        assign o_data[i]     = bus.out_data;
        assign o_group[i]    = bus.out_group;
        assign o_in_addr[i]  = bus.in_addr;
        assign o_w_addr[i]   = bus.w_addr;
        assign o_b_addr[i]   = bus.b_addr;

        dense_layer_tm #(
            .NEURON_NB (NEURON_NB),
            .IN_SIZE   (IN_SIZE),
            .WIDTH     (WIDTH),
            .LANES     (LANES),
            .RELU      ((i == 0) ? 1 : 0),
            .SHIFT     ((i == 2) ? 2 : 0)
        ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .start      (start),
            .busy       (busy[i]),
            .layer_done (ld[i]),
            .bus        (bus.master)
        );
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] x0, input logic [15:0] x1,
                                input logic [15:0] x2, input logic [15:0] x3,
                                input logic [7:0] w, input logic [7:0] b,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2);
        vec_t v;
        v.x = {x3, x2, x1, x0};
        v.w = w;
        v.b = b;
        v.e = {e2, e1, e0};
        return v;
    endfunction

    // Reference neuron: plain integer dot product, bias, then the per-DUT ReLU/shift
    function automatic logic [31:0] model(input int g, input int k, input int dut);
        int acc;
        logic signed [15:0] xs;
        logic signed [7:0]  ws;
        logic signed [7:0]  bs;
        acc = 0;
        for (int i = 0; i < IN_SIZE; i++) begin
            xs  = in_mem[i];
            ws  = w_mem[g*IN_SIZE+i][k*8 +: 8];
            acc = acc + int'(xs) * int'(ws);
        end
        bs  = b_mem[g][k*8 +: 8];
        acc = acc + int'(bs);
        if (dut == 0 && acc < 0) acc = 0;
        if (dut == 2) acc = acc >>> 2;
        return 32'(acc);
    endfunction

    task automatic load_uniform(input vec_t v);
        for (int i = 0; i < IN_SIZE; i++) in_mem[i] = v.x[i];
        for (int a = 0; a < GROUPS*IN_SIZE; a++) w_mem[a] = {v.w, v.w};
        for (int g = 0; g < GROUPS; g++) b_mem[g] = {v.b, v.b};
    endtask

    task automatic push_uniform(input vec_t v);
        exp_t e;
        for (int g = 0; g < GROUPS; g++) begin
            e.grp = 32'(g);
            for (int i = 0; i < NDUT; i++) e.d[i] = {v.e[i], v.e[i]};
            sbq.push_back(e);
        end
    endtask

    task automatic push_model();
        exp_t e;
        for (int g = 0; g < GROUPS; g++) begin
            e.grp = 32'(g);
            for (int i = 0; i < NDUT; i++) e.d[i] = {model(g, 1, i), model(g, 0, i)};
            sbq.push_back(e);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        for (int i = 0; i < NDUT; i++) begin
            chk({nm, "_busy"},      64'(busy[i]),      64'd0);
            chk({nm, "_done"},      64'(ld[i]),        64'd0);
            chk({nm, "_valid"},     64'(o_valid[i]),   64'd0);
            chk({nm, "_data"},      o_data[i],         64'd0);
            chk({nm, "_group"},     64'(o_group[i]),   64'd0);
            chk({nm, "_in_addr"},   64'(o_in_addr[i]), 64'd0);
            chk({nm, "_w_addr"},    64'(o_w_addr[i]),  64'd0);
            chk({nm, "_b_addr"},    64'(o_b_addr[i]),  64'd0);
        end
    endtask

    task automatic run_pass(input string nm, input int stall, input int restart_at, input int exp_lat);
        int n;
        int held;
        logic [63:0] snap_d;
        logic [0:0]  snap_g;
        logic [1:0]  snap_ia;
        logic [2:0]  snap_wa;
        ready = (stall == 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            chk({nm, "_busy_rise"}, 64'(busy[i]), 64'd1);
            chk({nm, "_done_clr"},  64'(ld[i]),   64'd0);
        end
        n = 0;
        held = 0;
        snap_d = '0; snap_g = '0; snap_ia = '0; snap_wa = '0;
        while (!ld[0] && n < 300) begin
            start = (n == restart_at);
            if (!ready && o_valid[0]) begin
                if (held == 0) begin
                    snap_d = o_data[0]; snap_g = o_group[0];
                    snap_ia = o_in_addr[0]; snap_wa = o_w_addr[0];
                end else begin
                    chk({nm, "_hold_valid"},   64'(o_valid[0]),   64'd1);
                    chk({nm, "_hold_data"},    o_data[0],         snap_d);
                    chk({nm, "_hold_group"},   64'(o_group[0]),   64'(snap_g));
                    chk({nm, "_hold_in_addr"}, 64'(o_in_addr[0]), 64'(snap_ia));
                    chk({nm, "_hold_w_addr"},  64'(o_w_addr[0]),  64'(snap_wa));
                end
                if (held == stall) ready = 1'b1;
                held++;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
        for (int i = 0; i < NDUT; i++) begin
            chk({nm, "_busy_fall"}, 64'(busy[i]), 64'd0);
            chk({nm, "_done_set"},  64'(ld[i]),   64'd1);
        end
        chk({nm, "_sb_empty"}, 64'(sbq.size()), 64'd0);
        ready = 1'b1;
    endtask

    // Scoreboard pops whenever a handshake will occur on the coming rising edge
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && ready && o_valid[0]) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got group %0d data %h, expected none", o_group[0], o_data[0]);
            end else begin
                e = sbq.pop_front();
                for (int i = 0; i < NDUT; i++) begin
                    chk($sformatf("out_valid_dut%0d", i), 64'(o_valid[i]), 64'd1);
                    chk($sformatf("out_group_dut%0d", i), 64'(o_group[i]), 64'(e.grp));
                    chk($sformatf("out_data_dut%0d_g%0d", i, e.grp), o_data[i], e.d[i]);
                end
            end
        end
    end

    initial begin
        vecs[0] = mk(16'd1, 16'd2, 16'd3, 16'd4, 8'h01, 8'h00, 32'd10, 32'd10, 32'd2);
        vecs[1] = mk(16'd1, 16'd2, 16'd3, 16'd4, 8'hFF, 8'h05, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFE);
        vecs[2] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 8'h80, 8'h7F,
                     32'h0100007F, 32'h0100007F, 32'h0040001F);
        vecs[3] = mk(16'd5, 16'hFFFD, 16'd7, 16'd0, 8'h02, 8'hFF, 32'd17, 32'd17, 32'd4);
        vecs[4] = mk(16'd100, 16'd200, 16'hFFCE, 16'd10, 8'h03, 8'h80, 32'd652, 32'd652, 32'd163);

        load_uniform(vecs[0]);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            load_uniform(vecs[v]);
            push_uniform(vecs[v]);
            run_pass($sformatf("vec%0d", v), 0, -1, 15);
        end

        load_uniform(vecs[0]);
        push_uniform(vecs[0]);
        run_pass("stall", 5, -1, 20);

        repeat (3) @(posedge clk);
        #1;
        chk("done_sticky", 64'(ld[0]), 64'd1);

        for (int i = 0; i < IN_SIZE; i++) in_mem[i] = 16'(i*4 - 5);
        for (int a = 0; a < GROUPS*IN_SIZE; a++) w_mem[a] = {8'(7 - a*5), 8'(a*3 - 4)};
        for (int g = 0; g < GROUPS; g++) b_mem[g] = {8'(g*9 - 6), 8'(3 - g*11)};
        push_model();
        run_pass("mixed", 0, -1, 15);

        load_uniform(vecs[0]);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_in_addr", 64'(o_in_addr[0]), 64'd2);
        reset_n = 1'b0;
        #1;
        check_reset_vals("midpass_reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("post_reset_idle_busy",  64'(busy[0]),    64'd0);
        chk("post_reset_idle_valid", 64'(o_valid[0]), 64'd0);

        push_uniform(vecs[0]);
        run_pass("restart_ignored", 0, 3, 15);

        push_uniform(vecs[0]);
        run_pass("fresh", 0, -1, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
